softmax_buf_ctrl: RTL and testbench

- Memory-side responder and job sequencer for the softmax engine.
- Accepts input vectors from a host stream into a ping-pong on-chip buffer, then drives the engine's init/start/start_addr/end_addr.
- Serves the engine's three read ports (max, stage-1 subtract, pre-subtract) with fixed 1-cycle read latency, and tracks engine done to retire buffers.
- Sits between the host/DMA side and the softmax engine.

---
 rtl/softmax_buf_ctrl_pkg.sv | 27 ++
 rtl/softmax_buf_ctrl_ram.sv | 38 +++
 rtl/softmax_buf_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_softmax_buf_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_buf_ctrl_pkg.sv
// Shared definitions for the softmax buffer controller.
// Holds the default geometry (element width, lanes, address width), the
// sequencer state encoding and the word-width helper.
package softmax_buf_ctrl_pkg;

  localparam int DATAWIDTH_DEF = 16;
  localparam int NUM_DEF       = 4;
  localparam int ADDRSIZE_DEF  = 8;
  localparam int TIMEOUT_DEF   = 1024;

  // Width of one buffer word: NUM lanes of DATAWIDTH bits.
  function automatic int word_w(input int dw, input int n);
    return dw * n;
  endfunction

  localparam int WORD_W_DEF = DATAWIDTH_DEF * NUM_DEF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    START   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    RETIRE  = 3'd5
  } seq_state_t;

endpackage

// File: rtl/softmax_buf_ctrl_ram.sv
// sm_buf_ram: one-write / one-read synchronous RAM.
// Ports:
//   clk, reset      clock and synchronous active-high reset (clears the
//                   read register only; array contents are kept)
//   we/waddr/wdata  write port
//   raddr/rdata     read port, data valid one cycle after raddr is sampled
// A read and a write to the same address in the same cycle returns the
// previous contents.
module sm_buf_ram #(
  parameter int WIDTH = 64,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/softmax_buf_ctrl.sv
// softmax_buf_ctrl: host-side ping-pong buffer and job sequencer for the
// softmax engine.
// Ports:
//   clk, reset                synchronous active-high reset
//   wr_valid/wr_ready/wr_data/wr_last   host word stream into the buffer
//   eng_init, eng_start       one-cycle pulses to the engine (init then start)
//   eng_start_addr/end_addr   word range of the active vector
//   eng_done                  engine done level
//   rd_*/sub0_*/sub1_*        three 1-cycle-latency read ports
//   busy                      sequencer not idle
//   job_done                  one-cycle pulse when a vector is retired
//   err_ovf, err_timeout      sticky error flags
//
// Handshake: a host beat transfers on a rising clk edge where wr_valid and
// wr_ready are both high; wr_data/wr_last are only meaningful while
// wr_valid is high, and wr_ready does not depend on wr_valid.
//
// The buffer is split into two banks by the address MSB. The write side
// fills wr_bank while the sequencer runs the engine on run_bank.
module softmax_buf_ctrl
  import softmax_buf_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int NUM       = NUM_DEF,
  parameter int ADDRSIZE  = ADDRSIZE_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DATAWIDTH*NUM-1:0]      wr_data,
  input  logic                          wr_last,
  output logic                          eng_init,
  output logic                          eng_start,
  output logic [ADDRSIZE-1:0]           eng_start_addr,
  output logic [ADDRSIZE-1:0]           eng_end_addr,
  input  logic                          eng_done,
  input  logic [ADDRSIZE-1:0]           rd_addr,
  output logic [DATAWIDTH*NUM-1:0]      rd_data,
  input  logic [ADDRSIZE-1:0]           sub0_addr,
  output logic [DATAWIDTH*NUM-1:0]      sub0_data,
  input  logic [ADDRSIZE-1:0]           sub1_addr,
  output logic [DATAWIDTH*NUM-1:0]      sub1_data,
  output logic                          busy,
  output logic                          job_done,
  output logic                          err_ovf,
  output logic                          err_timeout
);

  localparam int WORD_W = word_w(DATAWIDTH, NUM);
  localparam int PTR_W  = ADDRSIZE - 1;
  localparam int WD_W   = $clog2(TIMEOUT) + 1;

  // ---------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------
  logic [1:0]          bank_full;
  logic                wr_bank;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    len_q [2];
  logic                wr_fire;
  logic                wr_at_end;
  logic                wr_close;
  logic [ADDRSIZE-1:0] wr_addr;

  assign wr_ready  = ~bank_full[wr_bank];
  assign wr_fire   = wr_valid & wr_ready;
  assign wr_at_end = &wr_ptr;
  // A vector closes on its last word or when the bank runs out of room;
  // in the latter case the remaining beats start a new vector.
  assign wr_close  = wr_fire & (wr_last | wr_at_end);
  assign wr_addr   = {wr_bank, wr_ptr};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank  <= 1'b0;
      wr_ptr   <= '0;
      len_q[0] <= '0;
      len_q[1] <= '0;
      err_ovf  <= 1'b0;
    end else if (wr_fire) begin
      if (wr_close) begin
        len_q[wr_bank] <= wr_ptr;
        wr_ptr         <= '0;
        wr_bank        <= ~wr_bank;
        if (wr_at_end & ~wr_last) begin
          err_ovf <= 1'b1;
        end
      end else begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------
  seq_state_t       state_q;
  seq_state_t       state_d;
  logic             run_bank;
  logic [WD_W-1:0]  watchdog;
  logic [WD_W-1:0]  wd_inc;
  logic             in_wait;
  logic             wd_hit;
  logic             job_launch;

  assign in_wait    = (state_q == WAIT_HI) || (state_q == WAIT_LO);
  assign wd_inc     = watchdog + WD_W'(1);
  assign wd_hit     = in_wait && (wd_inc == WD_W'(TIMEOUT - 1));
  assign job_launch = (state_q == IDLE) && bank_full[run_bank];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bank_full[run_bank]) state_d = INIT;
      INIT:    state_d = START;
      START:   state_d = WAIT_HI;
      WAIT_HI: begin
        if (wd_hit)        state_d = RETIRE;
        else if (eng_done) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (wd_hit || !eng_done) state_d = RETIRE;
      end
      RETIRE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign eng_init  = (state_q == INIT);
  assign eng_start = (state_q == START);
  assign job_done  = (state_q == RETIRE);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      run_bank       <= 1'b0;
      watchdog       <= '0;
      eng_start_addr <= '0;
      eng_end_addr   <= '0;
      err_timeout    <= 1'b0;
    end else begin
      // Latch on the IDLE->INIT transition so the range is stable while
      // eng_init is high and holds until the next job.
      if (job_launch) begin
        eng_start_addr <= {run_bank, PTR_W'(0)};
        eng_end_addr   <= {run_bank, len_q[run_bank]};
      end
      if (state_q == START) begin
        watchdog <= '0;
      end else if (in_wait) begin
        watchdog <= wd_inc;
      end
      if (wd_hit) begin
        err_timeout <= 1'b1;
      end
      if (state_q == RETIRE) begin
        run_bank <= ~run_bank;
      end
    end
  end

  // Filling one bank and retiring the other can coincide; they never touch
  // the same bit because a full bank cannot accept writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full <= 2'b00;
    end else begin
      if (wr_close) begin
        bank_full[wr_bank] <= 1'b1;
      end
      if (state_q == RETIRE) begin
        bank_full[run_bank] <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Storage: one copy per read port, sharing the write port
  // ---------------------------------------------------------------------
  sm_buf_ram #(.WIDTH(WORD_W), .AW(ADDRSIZE)) u_ram_rd (
    .clk(clk), .reset(reset), .we(wr_fire), .waddr(wr_addr), .wdata(wr_data),
    .raddr(rd_addr), .rdata(rd_data)
  );

  sm_buf_ram #(.WIDTH(WORD_W), .AW(ADDRSIZE)) u_ram_sub0 (
    .clk(clk), .reset(reset), .we(wr_fire), .waddr(wr_addr), .wdata(wr_data),
    .raddr(sub0_addr), .rdata(sub0_data)
  );

  sm_buf_ram #(.WIDTH(WORD_W), .AW(ADDRSIZE)) u_ram_sub1 (
    .clk(clk), .reset(reset), .we(wr_fire), .waddr(wr_addr), .wdata(wr_data),
    .raddr(sub1_addr), .rdata(sub1_data)
  );

endmodule

// File: tb/tb_softmax_buf_ctrl.sv
// Testbench for softmax_buf_ctrl: write-side model, job scoreboard on
// eng_init, table-driven read checks and hand sequences for the multi-cycle
// corner cases (back-to-back banks, overflow, watchdog, reset mid-job).
module tb_softmax_buf_ctrl;

  localparam int DW = 16;
  localparam int NL = 4;
  localparam int AW = 8;
  localparam int TO = 16;
  localparam int W  = DW * NL;

  logic          clk;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [W-1:0]  wr_data;
  logic          wr_last;
  logic          eng_init;
  logic          eng_start;
  logic [AW-1:0] eng_start_addr;
  logic [AW-1:0] eng_end_addr;
  logic          eng_done;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic [AW-1:0] sub0_addr;
  logic [W-1:0]  sub0_data;
  logic [AW-1:0] sub1_addr;
  logic [W-1:0]  sub1_data;
  logic          busy;
  logic          job_done;
  logic          err_ovf;
  logic          err_timeout;

  softmax_buf_ctrl #(
    .DATAWIDTH(DW), .NUM(NL), .ADDRSIZE(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .eng_init(eng_init), .eng_start(eng_start),
    .eng_start_addr(eng_start_addr), .eng_end_addr(eng_end_addr),
    .eng_done(eng_done),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .sub0_addr(sub0_addr), .sub0_data(sub0_data),
    .sub1_addr(sub1_addr), .sub1_data(sub1_data),
    .busy(busy), .job_done(job_done),
    .err_ovf(err_ovf), .err_timeout(err_timeout)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]   model_mem [256];
  logic           m_bank;
  logic [6:0]     m_ptr;
  logic [15:0]    job_exp_q[$];   // {start_addr, end_addr} per expected job
  logic [3*W-1:0] exp_q[$];       // {rd, sub0, sub1} expected read data
  logic [15:0]    job_e;

  typedef struct {
    logic [AW-1:0]  ra;
    logic [AW-1:0]  sa;
    logic [AW-1:0]  pa;
    logic [3*W-1:0] exp;
  } rd_vec_t;

  rd_vec_t rd_tbl [4];

  task automatic check(input string name, input logic [3*W-1:0] act,
                       input logic [3*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string msg);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd();
    return {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
            16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
  endfunction

  // Model of one accepted beat: record data, and on vector close expect a job.
  task automatic model_write(input logic [W-1:0] d, input logic last);
    model_mem[{m_bank, m_ptr}] = d;
    if (last || m_ptr == 7'h7f) begin
      job_exp_q.push_back({m_bank, 7'h00, m_bank, m_ptr});
      m_ptr  = 7'h00;
      m_bank = ~m_bank;
    end else begin
      m_ptr = m_ptr + 7'h01;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset     = 1'b1;
    wr_valid  = 1'b0;
    wr_last   = 1'b0;
    wr_data   = '0;
    eng_done  = 1'b0;
    rd_addr   = '0;
    sub0_addr = '0;
    sub1_addr = '0;
    tick();
    tick();
    reset = 1'b0;
    job_exp_q.delete();
    exp_q.delete();
    m_bank = 1'b0;
    m_ptr  = 7'h00;
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic last);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    for (int i = 0; i < 40 && !wr_ready; i++) tick();
    if (!wr_ready) begin
      flag("wr_ready_wait", "wr_ready never rose");
      wr_valid = 1'b0;
      wr_last  = 1'b0;
    end else begin
      tick();
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      model_write(d, last);
    end
  endtask

  task automatic send_vector(input int n);
    for (int i = 0; i < n; i++) send_beat(rnd(), (i == n - 1));
  endtask

  // Engine emulation: after eng_start, raise done for two cycles, drop it,
  // then wait for the retire pulse.
  task automatic run_job();
    for (int i = 0; i < 20 && !eng_start; i++) tick();
    if (!eng_start) begin
      flag("eng_start_wait", "eng_start never pulsed");
    end else begin
      tick();
      eng_done = 1'b1;
      tick();
      tick();
      eng_done = 1'b0;
      for (int i = 0; i < 20 && !job_done; i++) tick();
      if (!job_done) flag("job_done_wait", "job_done never pulsed");
      tick();
    end
  endtask

  // ---------------- job scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && eng_init) begin
      if (job_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_init: start %0h end %0h, no job expected",
                 eng_start_addr, eng_end_addr);
      end else begin
        job_e = job_exp_q.pop_front();
        check("job_addrs", {eng_start_addr, eng_end_addr}, job_e);
      end
    end
  end

  // ---------------- global bound ----------------
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "global timeout");
  end

  // ---------------- test sequence ----------------
  logic [W-1:0] d3;
  logic [W-1:0] old80;
  int           k;

  initial begin
    do_reset();

    // Reset state
    check("rst_wr_ready", wr_ready, 1);
    check("rst_eng_init", eng_init, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_start_addr", eng_start_addr, 0);
    check("rst_end_addr", eng_end_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_job_done", job_done, 0);
    check("rst_errs", {err_ovf, err_timeout}, 0);
    check("rst_rd_data", {rd_data, sub0_data, sub1_data}, 0);

    // A: 4-word vector into bank 0, then init/start/done/retire
    send_vector(4);
    check("a_idle_at_fill", busy, 0);
    tick();
    check("a_init", eng_init, 1);
    check("a_start_lo", eng_start, 0);
    tick();
    check("a_start", eng_start, 1);
    check("a_init_lo", eng_init, 0);
    run_job();
    check("a_job_done_lo", job_done, 0);
    check("a_busy_lo", busy, 0);

    // B: table-driven reads on the three ports
    rd_tbl[0] = '{ra: 8'd2, sa: 8'd0, pa: 8'd3, exp: '0};
    rd_tbl[1] = '{ra: 8'd1, sa: 8'd3, pa: 8'd0, exp: '0};
    rd_tbl[2] = '{ra: 8'd3, sa: 8'd2, pa: 8'd1, exp: '0};
    rd_tbl[3] = '{ra: 8'd0, sa: 8'd0, pa: 8'd2, exp: '0};
    for (int i = 0; i < 4; i++)
      rd_tbl[i].exp = {model_mem[rd_tbl[i].ra], model_mem[rd_tbl[i].sa],
                       model_mem[rd_tbl[i].pa]};
    for (int i = 0; i < 4; i++) begin
      rd_addr   = rd_tbl[i].ra;
      sub0_addr = rd_tbl[i].sa;
      sub1_addr = rd_tbl[i].pa;
      exp_q.push_back(rd_tbl[i].exp);
      tick();
      check($sformatf("rd_tbl%0d", i), {rd_data, sub0_data, sub1_data},
            exp_q.pop_front());
    end

    // C: bank 1 then bank 0 back to back, third vector must stall
    send_vector(3);
    send_vector(2);
    d3       = rnd();
    wr_valid = 1'b1;
    wr_data  = d3;
    wr_last  = 1'b1;
    check("c_wr_ready_full", wr_ready, 0);
    eng_done = 1'b1;
    tick();
    tick();
    eng_done = 1'b0;
    for (int i = 0; i < 20 && !job_done; i++) tick();
    if (!job_done) flag("c_job_done_wait", "job_done never pulsed");
    check("c_ready_at_retire", wr_ready, 0);
    tick();
    check("c_ready_rises", wr_ready, 1);
    // Read 0x80 in the same cycle the stalled beat overwrites it.
    old80   = model_mem[8'h80];
    rd_addr = 8'h80;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    model_write(d3, 1'b1);
    check("c_rdw_old", rd_data, old80);
    tick();
    check("c_rdw_new", rd_data, d3);
    run_job();
    run_job();
    check("c_no_timeout", err_timeout, 0);
    check("c_no_ovf", err_ovf, 0);

    // D/E: 129 beats without wr_last, then no engine done at all
    do_reset();
    for (int i = 0; i < 129; i++) send_beat(rnd(), 1'b0);
    check("d_err_ovf", err_ovf, 1);
    for (int i = 0; i < 10 && !eng_start; i++) tick();
    if (!eng_start) begin
      flag("e_start_wait", "eng_start never pulsed");
    end else begin
      k = 0;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (err_timeout) begin
          k = i;
          break;
        end
      end
      check("e_timeout_latency", k, TO);
      check("e_job_done", job_done, 1);
      tick();
      check("e_busy_lo", busy, 0);
      check("e_job_done_lo", job_done, 0);
      check("e_sticky", {err_ovf, err_timeout}, 2'b11);
    end
    rd_addr   = 8'h80;
    sub0_addr = 8'h7f;
    sub1_addr = 8'h00;
    exp_q.push_back({model_mem[8'h80], model_mem[8'h7f], model_mem[8'h00]});
    tick();
    check("d_ovf_reads", {rd_data, sub0_data, sub1_data}, exp_q.pop_front());

    // F: reset during WAIT_LO
    do_reset();
    send_vector(2);
    for (int i = 0; i < 10 && !eng_start; i++) tick();
    if (!eng_start) flag("f_start_wait", "eng_start never pulsed");
    tick();
    eng_done = 1'b1;
    tick();
    check("f_busy_in_wait", busy, 1);
    reset = 1'b1;
    tick();
    check("f_rst_ctrl", {eng_init, eng_start, busy, job_done, err_ovf, err_timeout}, 0);
    check("f_rst_addrs", {eng_start_addr, eng_end_addr}, 0);
    check("f_rst_rd", {rd_data, sub0_data, sub1_data}, 0);
    check("f_rst_wr_ready", wr_ready, 1);
    reset    = 1'b0;
    eng_done = 1'b0;
    job_exp_q.delete();
    m_bank = 1'b0;
    m_ptr  = 7'h00;
    tick();
    tick();
    check("f_idle_after", busy, 0);

    check("jobs_drained", job_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
